// File: rtl/fetch_pair_gen.sv
// -----------------------------------------------------------------------------
// fetch_pair_gen
//
// Producer end of the fetch-buffer write interface. Keeps the fetch PC,
// requests aligned 64-bit instruction pairs from the I-cache (one request in
// flight at most), and presents each returned pair to the fetch buffer.
//
// Ports
//   clk, rstn         clock, synchronous active-low reset
//   redirect          backend redirect request (highest priority)
//   redirect_pc       redirect target, bits [1:0] ignored
//   buf_stall         fetch buffer cannot accept the packet this cycle
//   icache_req        request valid (only in REQ)
//   icache_addr       8-byte aligned request address
//   icache_ready      I-cache accepts the request
//   icache_rvalid     one-cycle response strobe
//   icache_rdata      {word at addr+4, word at addr}
//   pc                8-byte aligned base address of irin
//   irin              instruction pair, same packing as icache_rdata
//   flag              packet valid; buffer writes on flag && !buf_stall
//   if0, if1          slot 0 / slot 1 of irin hold a valid instruction
// -----------------------------------------------------------------------------
module fetch_pair_gen #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        buf_stall,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_ready,
    input  logic        icache_rvalid,
    input  logic [63:0] icache_rdata,
    output logic [31:0] pc,
    output logic [63:0] irin,
    output logic        flag,
    output logic        if0,
    output logic        if1
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Packet presented to the fetch buffer.
    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] irin;
        logic        flag;
        logic        if0;
        logic        if1;
    } pkt_t;

    state_t      state, state_nx;
    logic [31:2] fetch_pc, fetch_pc_nx;
    logic        drop, drop_nx;
    logic        load_pkt, clr_pkt;
    logic        hs;
    pkt_t        pkt;

    // Low PC bits are architecturally zero; keep them visibly consumed.
    logic unused_pc_bits;
    assign unused_pc_bits = ^redirect_pc[1:0];

    assign hs          = icache_req && icache_ready;
    assign icache_req  = (state == REQ);
    assign icache_addr = {fetch_pc[31:3], 3'b000};

    assign pc   = pkt.pc;
    assign irin = pkt.irin;
    assign flag = pkt.flag;
    assign if0  = pkt.if0;
    assign if1  = pkt.if1;

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        drop_nx     = drop;
        load_pkt    = 1'b0;
        clr_pkt     = 1'b0;
        unique case (state)
            REQ: begin
                if (redirect) begin
                    fetch_pc_nx = redirect_pc[31:2];
                    // The request just accepted is for the old PC: its
                    // response must be thrown away.
                    if (hs) begin
                        state_nx = WAIT;
                        drop_nx  = 1'b1;
                    end
                end else if (hs) begin
                    state_nx = WAIT;
                    drop_nx  = 1'b0;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_nx = redirect_pc[31:2];
                    drop_nx     = 1'b1;
                    if (icache_rvalid)
                        state_nx = REQ;
                end else if (icache_rvalid) begin
                    if (drop) begin
                        drop_nx  = 1'b0;
                        state_nx = REQ;
                    end else begin
                        load_pkt = 1'b1;
                        state_nx = HOLD;
                    end
                end
            end
            HOLD: begin
                // Redirect wins even if the buffer takes the packet this
                // cycle: the PC does not advance past it.
                if (redirect) begin
                    clr_pkt     = 1'b1;
                    fetch_pc_nx = redirect_pc[31:2];
                    state_nx    = REQ;
                end else if (!buf_stall) begin
                    clr_pkt     = 1'b1;
                    // Next aligned pair; 32-bit wrap falls out of the width.
                    fetch_pc_nx = {fetch_pc[31:3] + 29'd1, 1'b0};
                    state_nx    = REQ;
                end
            end
            default: state_nx = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= REQ;
            fetch_pc <= RESET_PC[31:2];
            drop     <= 1'b0;
            pkt      <= '0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            drop     <= drop_nx;
            if (load_pkt) begin
                pkt.flag <= 1'b1;
                pkt.pc   <= {fetch_pc[31:3], 3'b000};
                pkt.irin <= icache_rdata;
                // Entry at the odd word: slot 0 precedes the target.
                pkt.if0  <= ~fetch_pc[2];
                pkt.if1  <= 1'b1;
            end else if (clr_pkt) begin
                // pc/irin keep their last values once flag drops.
                pkt.flag <= 1'b0;
                pkt.if0  <= 1'b0;
                pkt.if1  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pair_gen.sv
module tb_fetch_pair_gen;

    logic        clk = 1'b0;
    logic        rstn, redirect, buf_stall;
    logic [31:0] redirect_pc;
    logic        icache_req, icache_ready, icache_rvalid;
    logic [31:0] icache_addr, pc;
    logic [63:0] icache_rdata, irin;
    logic        flag, if0, if1;

    // Second instance with a wrapping reset PC.
    logic        rstn2, redirect2, buf_stall2;
    logic [31:0] redirect_pc2;
    logic        icache_req2, icache_ready2, icache_rvalid2;
    logic [31:0] icache_addr2, pc2;
    logic [63:0] icache_rdata2, irin2;
    logic        flag2, if02, if12;

    int errors = 0;
    int checks = 0;
    int writes = 0;

    always #5 clk = ~clk;

    fetch_pair_gen dut (
        .clk(clk), .rstn(rstn), .redirect(redirect), .redirect_pc(redirect_pc),
        .buf_stall(buf_stall), .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_ready(icache_ready), .icache_rvalid(icache_rvalid),
        .icache_rdata(icache_rdata), .pc(pc), .irin(irin), .flag(flag),
        .if0(if0), .if1(if1)
    );

    fetch_pair_gen #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rstn(rstn2), .redirect(redirect2), .redirect_pc(redirect_pc2),
        .buf_stall(buf_stall2), .icache_req(icache_req2), .icache_addr(icache_addr2),
        .icache_ready(icache_ready2), .icache_rvalid(icache_rvalid2),
        .icache_rdata(icache_rdata2), .pc(pc2), .irin(irin2), .flag(flag2),
        .if0(if02), .if1(if12)
    );

    // Buffer-side write counter for the first instance.
    always @(posedge clk)
        if (rstn && flag && !buf_stall) writes <= writes + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] hpc;
    logic [63:0] hirin;

    initial begin
        rstn = 1'b0; redirect = 1'b0; redirect_pc = '0; buf_stall = 1'b0;
        icache_ready = 1'b1; icache_rvalid = 1'b0; icache_rdata = '0;
        rstn2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0; buf_stall2 = 1'b0;
        icache_ready2 = 1'b0; icache_rvalid2 = 1'b0; icache_rdata2 = '0;
        tick(); tick();

        // Reset state
        chk("rst_flag", flag, 0);
        chk("rst_if", {if0, if1}, 0);
        chk("rst_pc", pc, 0);
        chk("rst_irin", irin, 0);
        chk("rst_req", icache_req, 1);
        chk("rst_addr", icache_addr, 32'h1c00_0000);

        // 1: basic fetch at reset PC, 1-cycle latency
        rstn = 1'b1;
        tick();                                   // handshake -> WAIT
        chk("t1_wait_req", icache_req, 0);
        icache_ready = 1'b0; icache_rvalid = 1'b1; icache_rdata = 64'h1111_1111_2222_2222;
        tick();                                   // HOLD
        icache_rvalid = 1'b0;
        chk("t1_flag", flag, 1);
        chk("t1_pc", pc, 32'h1c00_0000);
        chk("t1_irin", irin, 64'h1111_1111_2222_2222);
        chk("t1_if", {if0, if1}, 2'b11);
        tick();                                   // accepted -> REQ
        chk("t1_flag_clr", flag, 0);
        chk("t1_if_clr", {if0, if1}, 0);
        chk("t1_next_addr", icache_addr, 32'h1c00_0008);
        chk("t1_writes", writes, 1);

        // 2: redirect in REQ to an unaligned target
        redirect = 1'b1; redirect_pc = 32'h3333_3334;
        tick();
        redirect = 1'b0;
        chk("t2_addr", icache_addr, 32'h3333_3330);
        icache_ready = 1'b1;
        tick();                                   // WAIT
        icache_ready = 1'b0; icache_rvalid = 1'b1; icache_rdata = 64'h3333_3333_4444_4444;
        buf_stall = 1'b1;
        tick();                                   // HOLD
        icache_rvalid = 1'b0;
        chk("t2_flag", flag, 1);
        chk("t2_if", {if0, if1}, 2'b01);
        chk("t2_pc", pc, 32'h3333_3330);
        chk("t2_irin", irin, 64'h3333_3333_4444_4444);

        // 3: stall for 4 cycles in HOLD
        hpc = pc; hirin = irin;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_flag", flag, 1);
            chk("t3_pc", pc, hpc);
            chk("t3_irin", irin, hirin);
            chk("t3_if", {if0, if1}, 2'b01);
            chk("t3_noreq", icache_req, 0);
        end
        chk("t3_writes_stalled", writes, 1);
        buf_stall = 1'b0;
        tick();
        chk("t3_writes", writes, 2);
        chk("t3_flag_clr", flag, 0);
        chk("t3_next_addr", icache_addr, 32'h3333_3338);

        // 4: redirect in WAIT, stale response two cycles later
        icache_ready = 1'b1;
        tick();                                   // WAIT for 0x33333338
        icache_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h7777_7778;
        tick();
        redirect = 1'b0;
        chk("t4_wait_req", icache_req, 0);
        tick();
        icache_rvalid = 1'b1; icache_rdata = 64'h5555_5555_6666_6666;
        tick();                                   // discarded -> REQ
        icache_rvalid = 1'b0;
        chk("t4_flag", flag, 0);
        chk("t4_req", icache_req, 1);
        chk("t4_addr", icache_addr, 32'h7777_7778);
        icache_ready = 1'b1;
        tick();
        icache_ready = 1'b0; icache_rvalid = 1'b1; icache_rdata = 64'haaaa_aaaa_bbbb_bbbb;
        tick();
        icache_rvalid = 1'b0;
        chk("t4_pkt_flag", flag, 1);
        chk("t4_pkt_pc", pc, 32'h7777_7778);
        chk("t4_pkt_irin", irin, 64'haaaa_aaaa_bbbb_bbbb);
        chk("t4_pkt_if", {if0, if1}, 2'b11);
        tick();
        chk("t4_next_addr", icache_addr, 32'h7777_7780);
        chk("t4_writes", writes, 3);

        // 5a: redirect and rvalid in the same WAIT cycle
        icache_ready = 1'b1;
        tick();
        icache_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h1234_5670;
        icache_rvalid = 1'b1; icache_rdata = 64'hdead_dead_dead_dead;
        tick();
        redirect = 1'b0; icache_rvalid = 1'b0;
        chk("t5a_flag", flag, 0);
        chk("t5a_addr", icache_addr, 32'h1234_5670);

        // 5b: redirect and handshake in the same REQ cycle
        redirect = 1'b1; redirect_pc = 32'h2000_0000; icache_ready = 1'b1;
        tick();
        redirect = 1'b0; icache_ready = 1'b0;
        chk("t5b_wait_req", icache_req, 0);
        icache_rvalid = 1'b1; icache_rdata = 64'hbeef_beef_beef_beef;
        tick();
        icache_rvalid = 1'b0;
        chk("t5b_flag", flag, 0);
        chk("t5b_addr", icache_addr, 32'h2000_0000);
        icache_ready = 1'b1;
        tick();
        icache_ready = 1'b0; icache_rvalid = 1'b1; icache_rdata = 64'hcafe_0001_cafe_0000;
        tick();
        icache_rvalid = 1'b0;
        chk("t5b_pkt_pc", pc, 32'h2000_0000);
        chk("t5b_pkt_irin", irin, 64'hcafe_0001_cafe_0000);
        chk("t5b_writes", writes, 3);

        // 5c: redirect in HOLD drops the packet, PC does not advance
        buf_stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h4000_0004;
        tick();
        redirect = 1'b0; buf_stall = 1'b0;
        chk("t5c_flag", flag, 0);
        chk("t5c_addr", icache_addr, 32'h4000_0000);
        chk("t5c_writes", writes, 3);

        // 6: wrapping reset PC on second instance, reset in HOLD
        rstn2 = 1'b1;
        chk("t6_rst_addr", icache_addr2, 32'hFFFF_FFF8);
        icache_ready2 = 1'b1;
        tick();
        icache_ready2 = 1'b0; icache_rvalid2 = 1'b1; icache_rdata2 = '1;
        tick();
        icache_rvalid2 = 1'b0;
        chk("t6_flag", flag2, 1);
        chk("t6_pc", pc2, 32'hFFFF_FFF8);
        chk("t6_irin", irin2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t6_if", {if02, if12}, 2'b11);
        tick();
        chk("t6_wrap_addr", icache_addr2, 32'h0000_0000);
        chk("t6_wrap_req", icache_req2, 1);
        icache_ready2 = 1'b1;
        tick();
        icache_ready2 = 1'b0; icache_rvalid2 = 1'b1; icache_rdata2 = 64'h0123_4567_89ab_cdef;
        buf_stall2 = 1'b1;
        tick();
        icache_rvalid2 = 1'b0;
        chk("t6_pkt0_pc", pc2, 32'h0000_0000);
        chk("t6_pkt0_flag", flag2, 1);
        rstn2 = 1'b0;
        tick();
        chk("t6_hold_rst_flag", flag2, 0);
        chk("t6_hold_rst_if", {if02, if12}, 0);
        chk("t6_hold_rst_addr", icache_addr2, 32'hFFFF_FFF8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
